aes_out_stream: RTL and testbench

//  Output stage after the cipher state-to-word packing. Buffers up to DEPTH

---
 rtl/aes_const.sv | 15 +
 rtl/aes_out_stream_if.sv | 25 ++
 rtl/aes_out_stream_blk_fifo.sv | 71 +++++++
 rtl/aes_out_stream.sv | 58 +++++
 tb/tb_aes_out_stream.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_const.sv
// Shared AES geometry: column count and derived block/index widths, plus the
// column-select helper used wherever a packed block is split into words.
package aes_const;

    localparam int Nb        = 4;
    localparam int AES_BLK_W = 32 * Nb;
    localparam int AES_IDX_W = $clog2(Nb);

    // Column 0 lives in the most significant word of the packed block.
    function automatic logic [31:0] blk_col(input logic [AES_BLK_W-1:0] blk,
                                            input logic [AES_IDX_W-1:0] idx);
        return blk[AES_BLK_W-1-32*int'(idx) -: 32];
    endfunction

endpackage

// File: rtl/aes_out_stream_if.sv
// Block-in / word-out handshake bundle for the AES output stream stage.
interface aes_out_stream_if;
    import aes_const::*;

    logic                 flush;
    logic                 blk_valid;
    logic                 blk_ready;
    logic [AES_BLK_W-1:0] blk_data;
    logic                 word_valid;
    logic                 word_ready;
    logic [31:0]          word_data;
    logic                 word_last;
    logic [AES_IDX_W-1:0] word_idx;

    modport master (
        output flush, blk_valid, blk_data, word_ready,
        input  blk_ready, word_valid, word_data, word_last, word_idx
    );

    modport slave (
        input  flush, blk_valid, blk_data, word_ready,
        output blk_ready, word_valid, word_data, word_last, word_idx
    );

endinterface

// File: rtl/aes_out_stream_blk_fifo.sv
// DEPTH-entry whole-block FIFO; flush clears pointers and count and wins over
// any push or pop in the same cycle.
module aes_blk_fifo
    import aes_const::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  logic [AES_BLK_W-1:0] wr_data,
    output logic [AES_BLK_W-1:0] rd_data,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty
);

    logic [DEPTH-1:0][AES_BLK_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/aes_out_stream.sv
// Buffers whole cipher blocks and streams each as Nb 32-bit words, column 0
// first. Word counter and column mux sit on the FIFO head.
module aes_out_stream
    import aes_const::*;
#(
    parameter int DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    aes_out_stream_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [AES_BLK_W-1:0] head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full, fifo_empty;
    logic [AES_IDX_W-1:0] word_idx_q, word_idx_d;
    logic                 push, word_pop, blk_pop, at_last;

    assign at_last  = (word_idx_q == AES_IDX_W'(Nb - 1));
    assign push     = bus.blk_valid && !fifo_full;
    assign word_pop = !fifo_empty && bus.word_ready;
    assign blk_pop  = word_pop && at_last;

    // Ready comes only from occupancy, so a full buffer refuses input even
    // in the cycle its head block is finishing.
    assign bus.blk_ready  = !fifo_full;
    assign bus.word_valid = (fifo_count != '0);
    assign bus.word_data  = fifo_empty ? '0 : blk_col(head, word_idx_q);
    assign bus.word_last  = !fifo_empty && at_last;
    assign bus.word_idx   = word_idx_q;

    always_comb begin
        word_idx_d = word_idx_q;
        if (bus.flush)    word_idx_d = '0;
        else if (word_pop) word_idx_d = at_last ? '0 : word_idx_q + AES_IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) word_idx_q <= '0;
        else     word_idx_q <= word_idx_d;
    end

    aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .push    (push),
        .pop     (blk_pop),
        .wr_data (bus.blk_data),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_aes_out_stream.sv
// Bench for aes_out_stream: queue-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_aes_out_stream;
    import aes_const::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_out_stream_if bus();

    aes_out_stream #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [AES_BLK_W-1:0] mq[$];
    logic [AES_BLK_W-1:0] src_q[$];
    logic [AES_BLK_W-1:0] exp_q[$];
    logic [31:0]          got_q[$];
    int                   midx = 0;
    int                   mode = 0;
    bit                   dut_acc = 1'b0;
    bit                   m_pu, m_po;
    bit                   pv = 1'b0;
    logic [31:0]          pd;
    logic [31:0]          pi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] col(input logic [AES_BLK_W-1:0] b, input int c);
        return b[AES_BLK_W-1-32*c -: 32];
    endfunction

    function automatic logic [AES_BLK_W-1:0] mk(input int k);
        logic [AES_BLK_W-1:0] b;
        for (int c = 0; c < Nb; c++) b[AES_BLK_W-1-32*c -: 32] = 32'(k * 256 + c);
        return b;
    endfunction

    // Model: a queue of whole blocks and a column pointer into the head.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            midx = 0;
        end else begin
            m_pu = bus.blk_valid && (mq.size() < DEPTH);
            m_po = (mq.size() != 0) && bus.word_ready;
            if (bus.flush) begin
                mq.delete();
                midx = 0;
            end else begin
                if (m_po) begin
                    if (midx == Nb - 1) begin
                        void'(mq.pop_front());
                        midx = 0;
                    end else midx++;
                end
                if (m_pu) mq.push_back(bus.blk_data);
            end
        end
    end

    always @(posedge clk) begin
        if (rst) dut_acc = 1'b0;
        else begin
            dut_acc = bus.blk_valid && bus.blk_ready && !bus.flush;
            if (bus.word_valid && bus.word_ready && !bus.flush) got_q.push_back(bus.word_data);
        end
    end

    always @(negedge clk) begin
        chk("word_valid", 32'(bus.word_valid), 32'(mq.size() != 0));
        chk("blk_ready", 32'(bus.blk_ready), 32'(mq.size() != DEPTH));
        if (mq.size() != 0) begin
            chk("word_data", bus.word_data, col(mq[0], midx));
            chk("word_idx", 32'(bus.word_idx), 32'(midx));
            chk("word_last", 32'(bus.word_last), 32'(midx == Nb - 1));
        end
        if (pv && !rst && !bus.flush && !bus.word_ready) begin
            chk("hold_data", bus.word_data, pd);
            chk("hold_idx", 32'(bus.word_idx), pi);
        end
        pv = bus.word_valid && !rst;
        pd = bus.word_data;
        pi = 32'(bus.word_idx);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
        if (dut_acc && src_q.size() != 0) void'(src_q.pop_front());
        dut_acc = 1'b0;
        bus.blk_valid  = (src_q.size() != 0);
        bus.blk_data   = (src_q.size() != 0) ? src_q[0] : '0;
        bus.word_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    endtask

    logic [31:0] t1w[4];
    logic [AES_BLK_W-1:0] b;

    initial begin
        bus.flush = 1'b0; bus.blk_valid = 1'b0; bus.blk_data = '0; bus.word_ready = 1'b0;
        t1w[0] = 32'h00112233; t1w[1] = 32'h44556677; t1w[2] = 32'h8899AABB; t1w[3] = 32'hCCDDEEFF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_word_valid", 32'(bus.word_valid), 0);
        chk("rst_blk_ready", 32'(bus.blk_ready), 1);
        chk("rst_word_data", bus.word_data, 0);
        chk("rst_word_idx", 32'(bus.word_idx), 0);
        chk("rst_word_last", 32'(bus.word_last), 0);
        rst = 1'b0;

        // Single block, consumer always ready
        mode = 1; got_q.delete();
        src_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
        cyc();
        chk("t1_pre_valid", 32'(bus.word_valid), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_valid", 32'(bus.word_valid), 1);
            chk("t1_data", bus.word_data, t1w[i]);
            chk("t1_last", 32'(bus.word_last), 32'(i == 3));
        end
        cyc();
        chk("t1_done", 32'(bus.word_valid), 0);

        // Three blocks against a stalled consumer
        mode = 0; got_q.delete();
        src_q.push_back(mk(1)); src_q.push_back(mk(2)); src_q.push_back(mk(3));
        repeat (4) cyc();
        chk("t2_full", 32'(bus.blk_ready), 0);
        chk("t2_held", 32'(src_q.size()), 1);
        mode = 1;
        repeat (4) cyc();
        chk("t2_still_full", 32'(bus.blk_ready), 0);
        cyc();
        chk("t2_ready_after_pop", 32'(bus.blk_ready), 1);
        cyc();
        chk("t2_third_taken", 32'(src_q.size()), 0);
        repeat (12) cyc();
        chk("t2_nwords", 32'(got_q.size()), 12);
        if (got_q.size() == 12) begin
            chk("t2_w0", got_q[0], 32'h00000100);
            chk("t2_w4", got_q[4], 32'h00000200);
            chk("t2_w11", got_q[11], 32'h00000303);
        end

        // Last-word pop and push in the same cycle
        mode = 0; got_q.delete();
        src_q.push_back(mk(4));
        repeat (2) cyc();
        mode = 1;
        for (int c = 0; c < 10 && !(bus.word_valid && bus.word_idx == 2'd3); c++) cyc();
        chk("t4_reach_last", 32'(bus.word_valid && bus.word_idx == 2'd3), 1);
        src_q.push_back(mk(5));
        bus.blk_valid = 1'b1; bus.blk_data = mk(5);
        cyc();
        chk("t4_valid", 32'(bus.word_valid), 1);
        chk("t4_idx", 32'(bus.word_idx), 0);
        chk("t4_data", bus.word_data, 32'h00000500);
        chk("t4_ready", 32'(bus.blk_ready), 1);
        chk("t4_prev_last", (got_q.size() != 0) ? got_q[got_q.size()-1] : 32'hX, 32'h00000403);
        repeat (4) cyc();
        chk("t4_drained", 32'(bus.word_valid), 0);

        // Asynchronous reset mid-block
        got_q.delete();
        src_q.push_back(mk(6));
        for (int c = 0; c < 20 && got_q.size() < 2; c++) cyc();
        chk("t5_two_words", 32'(got_q.size()), 2);
        #2 rst = 1'b1;
        #1;
        chk("t5_word_valid", 32'(bus.word_valid), 0);
        chk("t5_blk_ready", 32'(bus.blk_ready), 1);
        chk("t5_word_data", bus.word_data, 0);
        chk("t5_word_idx", 32'(bus.word_idx), 0);
        chk("t5_word_last", 32'(bus.word_last), 0);
        src_q.delete(); bus.blk_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        got_q.delete();
        src_q.push_back(mk(7));
        repeat (8) cyc();
        chk("t5_nwords", 32'(got_q.size()), 4);
        if (got_q.size() != 0) chk("t5_first", got_q[0], 32'h00000700);

        // Flush against a push into a non-full buffer, then a full buffer
        mode = 0; got_q.delete();
        src_q.push_back(mk(8));
        cyc();
        bus.flush = 1'b1;
        src_q.delete();
        cyc();
        bus.flush = 1'b0;
        chk("t6a_valid", 32'(bus.word_valid), 0);
        src_q.push_back(mk(9)); src_q.push_back(mk(10)); src_q.push_back(mk(11));
        repeat (4) cyc();
        chk("t6_full", 32'(bus.blk_ready), 0);
        chk("t6_src_valid", 32'(bus.blk_valid), 1);
        bus.flush = 1'b1;
        src_q.delete();
        cyc();
        bus.flush = 1'b0;
        chk("t6_valid", 32'(bus.word_valid), 0);
        chk("t6_ready", 32'(bus.blk_ready), 1);
        src_q.push_back(mk(12));
        mode = 1;
        repeat (8) cyc();
        chk("t6_nwords", 32'(got_q.size()), 4);
        if (got_q.size() != 0) chk("t6_first", got_q[0], 32'h00000C00);

        // 1000 random blocks against a randomly stalling consumer
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 1000; i++) begin
            b = {$urandom(), $urandom(), $urandom(), $urandom()};
            src_q.push_back(b);
            exp_q.push_back(b);
        end
        mode = 2;
        for (int c = 0; c < 40000 && !(src_q.size() == 0 && !bus.word_valid); c++) cyc();
        chk("t3_done", 32'(src_q.size() == 0 && !bus.word_valid), 1);
        chk("t3_nwords", 32'(got_q.size()), 4000);
        if (got_q.size() == 4000)
            for (int i = 0; i < 4000; i++) chk("t3_word", got_q[i], col(exp_q[i/4], i%4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
